// File: rtl/bus_ack_fifo.sv
//------------------------------------------------------------------------------
// Module      : bus_ack_fifo
// Description : Single-clock FIFO between flag/busy producers and a
//               first-word-fall-through flag/ack consumer, with occupancy
//               count, almost-full warning and sticky overflow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_ack_fifo #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 4,
  parameter  int AF_LEVEL = DEPTH - 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic             busy,
  output logic             flag_out,
  output logic [WIDTH-1:0] bus_out,
  input  logic             ack_in,
  output logic [AW:0]      count,
  output logic             almost_full,
  output logic             overflow,
  input  logic             clr_overflow
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] AF_CNT  = (AW + 1)'(AF_LEVEL);

  // Pointers carry one extra wrap bit above the storage index.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w_empty;
  logic             w_full;
  logic             w_wr;
  logic             w_rd;

  // Status is derived purely from registered pointers, so neither flag_in
  // nor ack_in has a combinational path to any output.
  always_comb begin
    w_empty     = (wr_ptr_q == rd_ptr_q);
    w_full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
    busy        = w_full;
    flag_out    = ~w_empty;
    count       = wr_ptr_q - rd_ptr_q;
    almost_full = (count >= AF_CNT);
    overflow    = overflow_q;
    bus_out     = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  // Accept decisions and next-state; a refused write only touches overflow.
  always_comb begin
    w_wr       = flag_in & ~w_full;
    w_rd       = ack_in & ~w_empty;
    wr_ptr_d   = w_wr ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = w_rd ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    overflow_d = overflow_q;
    if (flag_in && w_full) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Pointer and overflow state, discarded asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; an accepted word lands at the write index.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus_in;
    end
  end

endmodule

`default_nettype wire
